// File: rtl/stopwatch_ctrl_pkg.sv
// stopwatch_ctrl_pkg: shared state encodings and default timing parameters
package stopwatch_ctrl_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10
  } state_e;
  localparam int DEF_CLK_HZ     = 50000000;
  localparam int DEF_DEB_CYCLES = 500000;
endpackage

// File: rtl/key_debounce.sv
// key_debounce: 2-flop synchronizer, debouncer and one-cycle press pulse for an active-low key
module key_debounce
  import stopwatch_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_i,
  output logic press_o
);
  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] C_MAX = CW'(DEB_CYCLES);
  logic [1:0] sync_q;
  logic prev_q, lvl_q, lvl_d, arm_q, arm_d, press_q, press_d, acc;
  logic [CW-1:0] cnt_q, cnt_d;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync_q  <= 2'b11;
      prev_q  <= 1'b1;
      cnt_q   <= '0;
      lvl_q   <= 1'b1;
      arm_q   <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], key_i};
      prev_q  <= sync_q[1];
      cnt_q   <= cnt_d;
      lvl_q   <= lvl_d;
      arm_q   <= arm_d;
      press_q <= press_d;
    end
  // cnt counts consecutive equal samples; a key held through reset must be seen released before it may arm
  always_comb begin
    cnt_d   = (sync_q[1] != prev_q) ? CW'(1) : (cnt_q == C_MAX) ? C_MAX : cnt_q + CW'(1);
    acc     = cnt_d == C_MAX;
    lvl_d   = acc ? sync_q[1] : lvl_q;
    arm_d   = arm_q | (acc & sync_q[1]);
    press_d = acc & ~sync_q[1] & lvl_q & arm_q;
  end
  assign press_o = press_q;
endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: key-driven IDLE/RUN/PAUSE controller with tick prescaler, clear strobe and lap hold
module stopwatch_ctrl
  import stopwatch_ctrl_pkg::*;
#(
  parameter int CLK_HZ     = DEF_CLK_HZ,
  parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key0,
  input  logic       key1,
  input  logic       key2,
  output logic       cnt_en,
  output logic       cnt_clr,
  output logic       hold,
  output logic [1:0] state
);
  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(CLK_HZ - 1);
  logic [1:0] rst_q;
  logic rst_sync_n;
  logic [2:0] keys, ev;
  state_e state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic en_q, en_d, clr_q, clr_d, hold_q, hold_d, v1, v2, tick;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rst_q <= 2'b00;
    else rst_q <= {rst_q[0], 1'b1};
  assign rst_sync_n = rst_q[1];
  assign keys = {key2, key1, key0};
  for (genvar i = 0; i < 3; i++) begin : g_key
    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk    (clk),
      .rst_n  (rst_sync_n),
      .key_i  (keys[i]),
      .press_o(ev[i])
    );
  end
  always_ff @(posedge clk or negedge rst_sync_n)
    if (!rst_sync_n) begin
      state_q <= ST_IDLE;
      pre_q   <= '0;
      en_q    <= 1'b0;
      clr_q   <= 1'b0;
      hold_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      en_q    <= en_d;
      clr_q   <= clr_d;
      hold_q  <= hold_d;
    end
  // key1 outranks key0 outranks key2, but only among events valid in the current state
  always_comb begin
    v1      = ev[1] && state_q != ST_RUN;
    v2      = ev[2] && state_q == ST_RUN;
    state_d = state_q;
    hold_d  = hold_q;
    if (v1) state_d = ST_IDLE;
    else if (ev[0]) state_d = (state_q == ST_RUN) ? ST_PAUSE : ST_RUN;
    else if (v2) hold_d = ~hold_q;
    if (state_d == ST_IDLE) hold_d = 1'b0;
    clr_d = v1;
    tick  = state_q == ST_RUN && pre_q == PRE_MAX;
    en_d  = tick;
    pre_d = (state_q == ST_RUN) ? (tick ? '0 : pre_q + PW'(1)) : (state_q == ST_PAUSE) ? pre_q : '0;
  end
  assign cnt_en  = en_q;
  assign cnt_clr = clr_q;
  assign hold    = hold_q;
  assign state   = state_q;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: table-driven key sequences plus cycle-exact timing, bounce and reset scenarios
module tb_stopwatch_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [2:0] kb = 3'b111;
  logic cnt_en, cnt_clr, hold;
  logic [1:0] state;
  int pass_n = 0, total_n = 0, en_n = 0, clr_n = 0;
  typedef struct {
    logic [2:0] keys;
    logic [1:0] st;
    logic       hd;
    int         clr;
  } vec_t;
  vec_t tbl[16];
  stopwatch_ctrl #(.CLK_HZ(10), .DEB_CYCLES(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .key0   (kb[0]),
    .key1   (kb[1]),
    .key2   (kb[2]),
    .cnt_en (cnt_en),
    .cnt_clr(cnt_clr),
    .hold   (hold),
    .state  (state)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (cnt_en) en_n++;
    if (cnt_clr) clr_n++;
  end
  task automatic chk(input string nm, input int act, input int exp);
    total_n++;
    if (act != exp) $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    else pass_n++;
  endtask
  task automatic press(input logic [2:0] m);
    kb = ~m;
    repeat (10) @(negedge clk);
    kb = 3'b111;
    repeat (12) @(negedge clk);
  endtask
  initial begin
    int c0, e0, ex_st, ex_en;
    tbl[0]  = '{3'b010, 2'b00, 1'b0, 1};
    tbl[1]  = '{3'b001, 2'b01, 1'b0, 0};
    tbl[2]  = '{3'b100, 2'b01, 1'b1, 0};
    tbl[3]  = '{3'b010, 2'b01, 1'b1, 0};
    tbl[4]  = '{3'b100, 2'b01, 1'b0, 0};
    tbl[5]  = '{3'b100, 2'b01, 1'b1, 0};
    tbl[6]  = '{3'b001, 2'b10, 1'b1, 0};
    tbl[7]  = '{3'b100, 2'b10, 1'b1, 0};
    tbl[8]  = '{3'b001, 2'b01, 1'b1, 0};
    tbl[9]  = '{3'b001, 2'b10, 1'b1, 0};
    tbl[10] = '{3'b010, 2'b00, 1'b0, 1};
    tbl[11] = '{3'b100, 2'b00, 1'b0, 0};
    tbl[12] = '{3'b011, 2'b00, 1'b0, 1};
    tbl[13] = '{3'b001, 2'b01, 1'b0, 0};
    tbl[14] = '{3'b101, 2'b10, 1'b0, 0};
    tbl[15] = '{3'b011, 2'b00, 1'b0, 1};
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset state", int'(state), 0);
    chk("reset cnt_en", int'(cnt_en), 0);
    chk("reset cnt_clr", int'(cnt_clr), 0);
    chk("reset hold", int'(hold), 0);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("idle after reset", int'(state), 0);
    foreach (tbl[v]) begin
      c0 = clr_n;
      press(tbl[v].keys);
      chk($sformatf("vec%0d state", v), int'(state), int'(tbl[v].st));
      chk($sformatf("vec%0d hold", v), int'(hold), int'(tbl[v].hd));
      chk($sformatf("vec%0d clr pulses", v), clr_n - c0, tbl[v].clr);
    end
    // start, ticks, pause at prescaler 6, 50-cycle pause, resume, pause on a tick edge
    kb[0] = 1'b0;
    for (int k = 1; k <= 140; k++) begin
      @(negedge clk);
      ex_st = (k < 7) ? 0 : (k < 54) ? 1 : (k < 104) ? 2 : (k < 127) ? 1 : 2;
      ex_en = (k == 17 || k == 27 || k == 37 || k == 47 || k == 107 || k == 117 || k == 127) ? 1 : 0;
      chk($sformatf("timing k%0d state", k), int'(state), ex_st);
      chk($sformatf("timing k%0d cnt_en", k), int'(cnt_en), ex_en);
      chk($sformatf("timing k%0d cnt_clr", k), int'(cnt_clr), 0);
      if (k == 20 || k == 57 || k == 107 || k == 130) kb[0] = 1'b1;
      if (k == 47 || k == 97 || k == 120) kb[0] = 1'b0;
    end
    repeat (10) @(negedge clk);
    // 2-cycle bounces must not be accepted; the stable press that follows resumes exactly once
    for (int b = 0; b < 8; b++) begin
      kb[0] = b[1];
      @(negedge clk);
      chk($sformatf("bounce b%0d state", b), int'(state), 2);
    end
    kb[0] = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k == 10) kb[0] = 1'b1;
      if (k == 6 || k == 7 || k == 30) chk($sformatf("bounce k%0d state", k), int'(state), (k < 7) ? 2 : 1);
    end
    e0 = en_n;
    press(3'b100);
    chk("lap hold set", int'(hold), 1);
    chk("ticks during lap", (en_n - e0 >= 2) ? 1 : 0, 1);
    chk("lap keeps run", int'(state), 1);
    // reset mid-RUN with key0 held through reset release
    kb[0] = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("async rst state", int'(state), 0);
    chk("async rst hold", int'(hold), 0);
    chk("async rst cnt_en", int'(cnt_en), 0);
    chk("async rst cnt_clr", int'(cnt_clr), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      chk($sformatf("held k%0d state", k), int'(state), 0);
      chk($sformatf("held k%0d cnt_en", k), int'(cnt_en), 0);
      chk($sformatf("held k%0d cnt_clr", k), int'(cnt_clr), 0);
    end
    kb[0] = 1'b1;
    repeat (15) @(negedge clk);
    chk("release no event", int'(state), 0);
    press(3'b001);
    chk("re-press runs", int'(state), 1);
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
